// File: rtl/step_move_engine_if.sv
// Command handshake bundle for step_move_engine: one relative move, pause or NOP
// per accepted cmd_valid/cmd_ready transfer.
interface step_move_engine_if #(
  parameter int CNT_W = 8,
  parameter int DLY_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_steps;
  logic [DLY_W-1:0] cmd_delay;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_steps,
    output cmd_delay,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_steps,
    input  cmd_delay,
    output cmd_ready
  );
endinterface

// File: rtl/step_move_engine.sv
// Motion micro-sequencer: runs one full/half-step relative move or timed pause per
// command, owns the motor position register and strobes step_pulse on every update.
module step_move_engine #(
  parameter int POS_W = 8,
  parameter int CNT_W = 8,
  parameter int DLY_W = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  step_move_engine_if.slave   cmd,
  input  logic                abort,
  input  logic                pos_load,
  input  logic [POS_W-1:0]    pos_in,
  output logic [POS_W-1:0]    position,
  output logic                step_pulse,
  output logic                dir,
  output logic [CNT_W-1:0]    steps_left,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_FULL  = 2'b00,
    OP_HALF  = 2'b01,
    OP_PAUSE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] INC_FULL = {{(POS_W-2){1'b0}}, 2'b10};
  localparam logic [POS_W-1:0] INC_HALF = {{(POS_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  op_t              op_r, op_s;
  logic [DLY_W-1:0] dly_r, dly_s;
  logic [DLY_W-1:0] cnt_r, cnt_s;
  logic [POS_W-1:0] pos_r, pos_s;
  logic [POS_W-1:0] inc_s;
  logic [CNT_W-1:0] left_r, left_s;
  logic             dir_r, dir_s;
  logic             step_s;
  logic             busy_r, done_r, ready_r;

  // Unsigned magnitude of a two's-complement count; the most negative value maps to 2^(CNT_W-1).
  function automatic logic [CNT_W-1:0] magnitude(input logic [CNT_W-1:0] v);
    if (v[CNT_W-1]) begin
      magnitude = ~v + CNT_ONE;
    end else begin
      magnitude = v;
    end
  endfunction

  // Next-state and next-datapath logic for the sequencer.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    dly_s   = dly_r;
    cnt_s   = cnt_r;
    pos_s   = pos_r;
    left_s  = left_r;
    dir_s   = dir_r;
    step_s  = 1'b0;
    inc_s   = (op_r == OP_FULL) ? INC_FULL : INC_HALF;
    case (state_r)
      ST_IDLE: begin
        if (pos_load) begin
          pos_s = pos_in;
        end else begin
          pos_s = pos_r;
        end
        if (cmd.cmd_valid) begin
          op_s   = op_t'(cmd.cmd_op);
          dly_s  = cmd.cmd_delay;
          left_s = magnitude(cmd.cmd_steps);
          case (op_t'(cmd.cmd_op))
            OP_FULL, OP_HALF: begin
              dir_s   = cmd.cmd_steps[CNT_W-1];
              state_s = ST_STEP;
            end
            OP_PAUSE: begin
              cnt_s = cmd.cmd_delay;
              if (cmd.cmd_delay == DLY_ZERO) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_WAIT;
              end
            end
            default: begin
              state_s = ST_DONE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        // Abort wins over a pending step: no position change and no strobe.
        if (abort) begin
          state_s = ST_DONE;
        end else if (left_r == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          step_s = 1'b1;
          pos_s  = dir_r ? (pos_r - inc_s) : (pos_r + inc_s);
          left_s = left_r - CNT_ONE;
          if (dly_r == DLY_ZERO) begin
            state_s = ST_STEP;
          end else begin
            cnt_s   = dly_r;
            state_s = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - DLY_ONE;
          if (cnt_r <= DLY_ONE) begin
            state_s = (op_r == OP_PAUSE) ? ST_DONE : ST_STEP;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      op_r    <= OP_NOP;
      dly_r   <= DLY_ZERO;
      cnt_r   <= DLY_ZERO;
      pos_r   <= {POS_W{1'b0}};
      left_r  <= CNT_ZERO;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      dly_r   <= dly_s;
      cnt_r   <= cnt_s;
      pos_r   <= pos_s;
      left_r  <= left_s;
      dir_r   <= dir_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // step_pulse is decoded in-cycle so that a same-cycle abort can suppress it.
  assign step_pulse    = step_s;
  assign position      = pos_r;
  assign steps_left    = left_r;
  assign dir           = dir_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cmd.cmd_ready = ready_r;

endmodule

// File: tb/tb_step_move_engine.sv
// Self-checking bench for step_move_engine: directed vector table, async reset
// sequence and randomized commands against a timeline-based reference model.
module tb_step_move_engine;
  localparam int POS_W = 8;
  localparam int CNT_W = 8;
  localparam int DLY_W = 20;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             abort;
  logic             pos_load;
  logic [POS_W-1:0] pos_in;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic [CNT_W-1:0] steps_left;
  logic             busy;
  logic             done;

  step_move_engine_if #(.CNT_W(CNT_W), .DLY_W(DLY_W)) cmd_if ();

  step_move_engine #(.POS_W(POS_W), .CNT_W(CNT_W), .DLY_W(DLY_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cmd_if),
    .abort      (abort),
    .pos_load   (pos_load),
    .pos_in     (pos_in),
    .position   (position),
    .step_pulse (step_pulse),
    .dir        (dir),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic       done;
    logic       busy;
    logic       ready;
    logic       dir;
    logic [7:0] pos;
    logic [7:0] left;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  steps;
    logic [19:0] dly;
    logic        ld;
    logic [7:0]  pin;
    int          abort_at;
    int          exp_pulses;
    int          exp_done;
    logic [7:0]  exp_pos;
    logic [7:0]  exp_left;
    logic        exp_dir;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  obs_t q[$];
  logic [7:0] m_pos  = 8'd0;
  logic [7:0] m_left = 8'd0;
  logic       m_dir  = 1'b0;
  vec_t tbl[10];

  function automatic obs_t observe();
    return {step_pulse, done, busy, cmd_if.cmd_ready, dir, position, steps_left};
  endfunction

  function automatic obs_t mk(input logic p, input logic d, input logic [7:0] pos,
                              input logic [7:0] left, input logic dr);
    return {p, d, 1'b1, 1'b0, dr, pos, left};
  endfunction

  task automatic show_fail(input string name, input obs_t got, input obs_t exp);
    $display("FAIL %s t=%0t: got pulse=%b done=%b busy=%b ready=%b dir=%b pos=%0d left=%0d, expected pulse=%b done=%b busy=%b ready=%b dir=%b pos=%0d left=%0d",
             name, $time, got.pulse, got.done, got.busy, got.ready, got.dir, got.pos, got.left,
             exp.pulse, exp.done, exp.busy, exp.ready, exp.dir, exp.pos, exp.left);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expands an accepted command into its cycle-by-cycle expected observation timeline.
  task automatic plan(input logic [1:0] op, input logic [7:0] st, input logic [19:0] dl,
                      input logic [7:0] p0);
    int n, mag, inc, sg, d;
    logic nd;
    logic [7:0] pe;
    n   = int'($signed(st));
    mag = (n < 0) ? -n : n;
    d   = int'(dl);
    if (op == 2'b00 || op == 2'b01) begin
      nd  = (n < 0);
      inc = (op == 2'b00) ? 2 : 1;
      sg  = nd ? -1 : 1;
      for (int i = 0; i < mag; i++) begin
        q.push_back(mk(1'b1, 1'b0, 8'(int'(p0) + sg * i * inc), 8'(mag - i), nd));
        for (int j = 0; j < d; j++)
          q.push_back(mk(1'b0, 1'b0, 8'(int'(p0) + sg * (i + 1) * inc), 8'(mag - i - 1), nd));
      end
      pe = 8'(int'(p0) + sg * mag * inc);
      q.push_back(mk(1'b0, 1'b0, pe, 8'd0, nd));
      q.push_back(mk(1'b0, 1'b1, pe, 8'd0, nd));
    end else begin
      if (op == 2'b10) begin
        for (int j = 0; j < d; j++) q.push_back(mk(1'b0, 1'b0, p0, 8'(mag), m_dir));
      end
      q.push_back(mk(1'b0, 1'b1, p0, 8'(mag), m_dir));
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] st,
                       input logic [19:0] dl, input logic ab, input logic ld,
                       input logic [7:0] pin, output obs_t got);
    obs_t e;
    logic active, aborted;
    @(negedge clk);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_steps = st;
    cmd_if.cmd_delay = dl;
    abort            = ab;
    pos_load         = ld;
    pos_in           = pin;
    #1;
    got    = observe();
    active = (q.size() != 0);
    if (active) e = q[0];
    else        e = {1'b0, 1'b0, 1'b0, 1'b1, m_dir, m_pos, m_left};
    aborted = active && ab && !e.done;
    if (aborted) e.pulse = 1'b0;
    checks++;
    if (got !== e) begin
      failures++;
      show_fail("cycle", got, e);
    end
    if (active) begin
      void'(q.pop_front());
      if (aborted) begin
        q.delete();
        q.push_back(mk(1'b0, 1'b1, e.pos, e.left, e.dir));
      end
      if (e.done) begin
        m_pos  = e.pos;
        m_left = e.left;
        m_dir  = e.dir;
      end
    end else begin
      if (ld) m_pos = pin;
      if (v) plan(op, st, dl, m_pos);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t g;
    obs_t rst_exp;
    rst_exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};

    tbl[0] = '{2'b00, 8'd3,   20'd2, 1'b1, 8'd0,   -1, 3,   11,  8'd6,   8'd0, 1'b0};
    tbl[1] = '{2'b01, 8'h80,  20'd0, 1'b1, 8'd5,   -1, 128, 130, 8'd133, 8'd0, 1'b1};
    tbl[2] = '{2'b10, 8'd0,   20'd5, 1'b1, 8'd77,  -1, 0,   6,   8'd77,  8'd0, 1'b1};
    tbl[3] = '{2'b10, 8'd0,   20'd0, 1'b0, 8'd0,   -1, 0,   1,   8'd77,  8'd0, 1'b1};
    tbl[4] = '{2'b00, 8'd10,  20'd4, 1'b1, 8'd0,   11, 2,   12,  8'd4,   8'd8, 1'b0};
    tbl[5] = '{2'b00, 8'd4,   20'd1, 1'b1, 8'd250, -1, 4,   10,  8'd2,   8'd0, 1'b0};
    tbl[6] = '{2'b11, 8'd0,   20'd0, 1'b0, 8'd0,   -1, 0,   1,   8'd2,   8'd0, 1'b0};
    tbl[7] = '{2'b00, 8'd0,   20'd3, 1'b0, 8'd0,   -1, 0,   2,   8'd2,   8'd0, 1'b0};
    tbl[8] = '{2'b01, 8'd2,   20'd0, 1'b1, 8'd0,   1,  0,   2,   8'd0,   8'd2, 1'b0};
    tbl[9] = '{2'b00, 8'hFF,  20'd2, 1'b1, 8'd1,   -1, 1,   5,   8'd255, 8'd0, 1'b1};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b11;
    cmd_if.cmd_steps = 8'd0;
    cmd_if.cmd_delay = 20'd0;
    abort            = 1'b0;
    pos_load         = 1'b0;
    pos_in           = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    g = observe();
    checks++;
    if (g !== rst_exp) begin
      failures++;
      show_fail("reset_state", g, rst_exp);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      int pulses;
      int done_at;
      pulses  = 0;
      done_at = -1;
      for (int c = 0; c <= tbl[i].exp_done + 2; c++) begin
        cycle(c == 0, tbl[i].op, tbl[i].steps, tbl[i].dly, c == tbl[i].abort_at,
              (c == 0) ? tbl[i].ld : (c == 2 && c <= tbl[i].exp_done),
              (c == 0) ? tbl[i].pin : 8'd99, g);
        if (g.pulse) pulses++;
        if (g.done && done_at < 0) done_at = c;
      end
      check_int($sformatf("vec%0d_pulses", i), pulses, tbl[i].exp_pulses);
      check_int($sformatf("vec%0d_done_cycle", i), done_at, tbl[i].exp_done);
      check_int($sformatf("vec%0d_position", i), int'(g.pos), int'(tbl[i].exp_pos));
      check_int($sformatf("vec%0d_steps_left", i), int'(g.left), int'(tbl[i].exp_left));
      check_int($sformatf("vec%0d_dir", i), int'(g.dir), int'(tbl[i].exp_dir));
    end

    // Asynchronous reset in the middle of a long WAIT.
    cycle(1'b1, 2'b00, 8'd3, 20'd20, 1'b0, 1'b1, 8'd10, g);
    repeat (5) cycle(1'b0, 2'b11, 8'd0, 20'd0, 1'b0, 1'b0, 8'd0, g);
    #2 reset_n = 1'b0;
    #1;
    g = observe();
    checks++;
    if (g !== rst_exp) begin
      failures++;
      show_fail("async_reset_mid_wait", g, rst_exp);
    end
    q.delete();
    m_pos  = 8'd0;
    m_left = 8'd0;
    m_dir  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) cycle(1'b0, 2'b00, 8'd5, 20'd0, 1'b0, 1'b0, 8'd0, g);

    for (int n = 0; n < 2500; n++) begin
      logic [1:0]  op;
      logic [7:0]  st;
      logic [19:0] dl;
      op = 2'($urandom_range(0, 3));
      if (op < 2'd2) begin
        if ($urandom_range(0, 63) == 0) st = 8'h80;
        else                            st = 8'($urandom_range(0, 40)) - 8'd20;
      end else begin
        st = 8'd0;
      end
      dl = 20'($urandom_range(0, 3));
      cycle($urandom_range(0, 2) == 0, op, st, dl, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0, 8'($urandom), g);
    end

    for (int n = 0; n < 600 && q.size() != 0; n++)
      cycle(1'b0, 2'b11, 8'd0, 20'd0, 1'b0, 1'b0, 8'd0, g);
    check_int("drain_to_idle", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
